instr_fetch: RTL

Instruction fetch unit: the initiator that drives the byte-addressed, little-endian, combinational-read instruction memory. Holds the PC, presents it as the fetch address, and registers the returned 32-bit word into a single-entry output stage with a valid/ready handshake toward decode. Supports control-flow redirect, and detects misaligned and out-of-range PCs. Sits between the instruction memory and the decode stage in the lab single-issue core.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/instr_fetch.sv | 112 +++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states and
// instruction-size constants used for PC alignment checks.
package fetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] ALIGN_MASK  = 32'(INSTR_BYTES - 1);

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: drives the PC as the instruction-memory address and
// registers the returned word into a single-entry valid/ready output stage.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int          XLEN     = 5,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    // Last PC whose full word lies inside the 2**XLEN-byte memory.
    localparam logic [31:0] PC_MAX = 32'((64'd1 << XLEN) - 64'(INSTR_BYTES));

    // Handshake: an entry moves to decode on a rising edge where out_valid and
    // out_ready are both high and redirect_valid is low; a redirect flushes the
    // entry instead. out_pc/out_instr never change while out_valid && !out_ready.

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q;
    logic         slot_free;
    logic         pc_legal;
    logic         handshake;
    logic         do_load;
    logic         do_fault;

    assign imem_addr = pc_q;
    assign slot_free = !out_valid || out_ready;
    assign pc_legal  = ((pc_q & ALIGN_MASK) == 32'h0) && (pc_q <= PC_MAX);
    assign handshake = out_valid && out_ready && !redirect_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        do_load  = 1'b0;
        do_fault = 1'b0;
        if (redirect_valid) begin
            state_d = FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (slot_free) begin
                        if (pc_legal) begin
                            do_load = 1'b1;
                        end else begin
                            do_fault = 1'b1;
                            state_d  = FAULT;
                        end
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            out_valid   <= 1'b0;
            out_pc      <= 32'h0;
            out_instr   <= 32'h0;
            fault       <= 1'b0;
            fault_pc    <= 32'h0;
            fetch_count <= 32'h0;
        end else if (redirect_valid) begin
            out_valid <= 1'b0;
            pc_q      <= redirect_pc;
            fault     <= 1'b0;
        end else begin
            if (handshake) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (do_load) begin
                out_instr <= imem_data;
                out_pc    <= pc_q;
                out_valid <= 1'b1;
                pc_q      <= pc_q + 32'(INSTR_BYTES);
            end else if (handshake) begin
                out_valid <= 1'b0;
            end
            if (do_fault) begin
                fault    <= 1'b1;
                fault_pc <= pc_q;
            end
        end
    end

endmodule
